proc_trace_capture: RTL and testbench

- Receiving end of the processor trace interface (`trace_val`/`trace_addr`/`trace_data`) driven by `ProcScycle` and later processor variants.
- Timestamps each valid trace beat with a free-running cycle count.
- Buffers the stamped beats in a FIFO and drains them through a val/rdy dequeue port.
- Used by on-FPGA debug and by benches that compare a trace out of band instead of polling `proc_trace_val`.

---
 rtl/proc_trace_capture_pkg.sv | 17 +
 rtl/proc_trace_capture_fifo.sv | 83 ++++++++
 rtl/proc_trace_capture.sv | 104 ++++++++++
 tb/tb_proc_trace_capture.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/proc_trace_capture_pkg.sv
// ---------------------------------------------------------------------------
// ProcTracePkg
//   Shared types and constants for the processor trace capture block.
//   - TRACE_CNT_BITS : default width of the cycle and drop counters
//   - trace_entry_t  : one stamped trace beat (addr, data, cycle stamp)
// ---------------------------------------------------------------------------
package ProcTracePkg;

    localparam int TRACE_CNT_BITS = 32;

    typedef struct packed {
        logic [31:0]               addr;
        logic [31:0]               data;
        logic [TRACE_CNT_BITS-1:0] cycle;
    } trace_entry_t;

endpackage

// File: rtl/proc_trace_capture_fifo.sv
// ---------------------------------------------------------------------------
// TraceFifo
//   Storage, pointers and occupancy for the trace capture buffer.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     clear           : synchronous flush; same-cycle enq/deq are discarded
//     enq, enq_data   : write one entry (caller guarantees !full or deq)
//     deq, deq_data   : pop head (caller guarantees !empty); head is
//                       combinational from storage at the read pointer
//     full, empty     : occupancy flags
//     count           : current occupancy (0..p_depth)
// ---------------------------------------------------------------------------
module TraceFifo #(
    parameter int p_depth = 8,
    parameter int p_width = 96
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       enq,
    input  logic [p_width-1:0]         enq_data,
    input  logic                       deq,
    output logic [p_width-1:0]         deq_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(p_depth):0]   count
);

    localparam int AW = $clog2(p_depth);
    localparam int CW = AW + 1;

    // Storage carries no reset: only pointers and occupancy define validity.
    logic [p_width-1:0] mem [p_depth];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q,  cnt_d;

    assign full     = (cnt_q == CW'(p_depth));
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;
    assign deq_data = mem[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clear) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (enq) wptr_d = wptr_q + AW'(1);
            if (deq) rptr_d = rptr_q + AW'(1);
            case ({enq, deq})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // When full with a simultaneous pop, wptr == rptr: the head is read out
    // combinationally this cycle and overwritten at the edge, which is safe.
    always_ff @(posedge clk) begin
        if (enq && !clear && !rst)
            mem[wptr_q] <= enq_data;
    end

endmodule

// File: rtl/proc_trace_capture.sv
// ---------------------------------------------------------------------------
// proc_trace_capture
//   Timestamps processor trace beats with a free-running cycle counter and
//   buffers them in a FIFO drained through a val/rdy port.
//   Ports:
//     clk, rst                         : clock, synchronous active-high reset
//     clear                            : flush FIFO and status (counter runs on)
//     en                               : capture enable (ignored beats are not drops)
//     trace_val/addr/data              : trace input beat
//     deq_val/rdy, deq_addr/data/cycle : head of the capture FIFO
//     count                            : occupancy
//     overflow                         : sticky, a beat was dropped on full
//     drop_count                       : saturating count of dropped beats
// ---------------------------------------------------------------------------
module proc_trace_capture
    import ProcTracePkg::*;
#(
    parameter int p_depth    = 8,
    parameter int p_cnt_bits = TRACE_CNT_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      en,
    input  logic                      trace_val,
    input  logic [31:0]               trace_addr,
    input  logic [31:0]               trace_data,
    output logic                      deq_val,
    input  logic                      deq_rdy,
    output logic [31:0]               deq_addr,
    output logic [31:0]               deq_data,
    output logic [p_cnt_bits-1:0]     deq_cycle,
    output logic [$clog2(p_depth):0]  count,
    output logic                      overflow,
    output logic [p_cnt_bits-1:0]     drop_count
);

    localparam int EW = 64 + p_cnt_bits;

    logic [p_cnt_bits-1:0] cycle_q, cycle_d;
    logic                  ovf_q,   ovf_d;
    logic [p_cnt_bits-1:0] drop_q,  drop_d;

    logic          full, empty;
    logic          beat, deq_fire, enq, drop;
    logic [EW-1:0] enq_entry, head_entry;

    assign beat     = trace_val & en;
    assign deq_fire = deq_val & deq_rdy;
    // A full FIFO still accepts a beat when the head leaves in the same cycle.
    assign enq      = beat & (~full | deq_fire);
    assign drop     = beat & full & ~deq_fire;

    assign enq_entry = {trace_addr, trace_data, cycle_q};

    TraceFifo #(
        .p_depth (p_depth),
        .p_width (EW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .enq      (enq),
        .enq_data (enq_entry),
        .deq      (deq_fire),
        .deq_data (head_entry),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    assign deq_val    = ~empty;
    assign deq_addr   = head_entry[EW-1 -: 32];
    assign deq_data   = head_entry[EW-33 -: 32];
    assign deq_cycle  = head_entry[p_cnt_bits-1:0];
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

    always_comb begin
        cycle_d = cycle_q + p_cnt_bits'(1);
        ovf_d   = ovf_q;
        drop_d  = drop_q;
        if (clear) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + p_cnt_bits'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            cycle_q <= cycle_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_proc_trace_capture.sv
module tb_proc_trace_capture;

    localparam int DEPTH = 8;
    localparam int CB    = 6;   // narrow counters so wrap and saturation are reachable
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst, clear, en, trace_val, deq_rdy;
    logic [31:0]   trace_addr, trace_data;
    logic          deq_val, overflow;
    logic [31:0]   deq_addr, deq_data;
    logic [CB-1:0] deq_cycle, drop_count;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    proc_trace_capture #(.p_depth(DEPTH), .p_cnt_bits(CB)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .en         (en),
        .trace_val  (trace_val),
        .trace_addr (trace_addr),
        .trace_data (trace_data),
        .deq_val    (deq_val),
        .deq_rdy    (deq_rdy),
        .deq_addr   (deq_addr),
        .deq_data   (deq_data),
        .deq_cycle  (deq_cycle),
        .count      (count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    // Behavioural model: a queue of stamped beats plus status scalars.
    typedef struct {
        logic [31:0]   a;
        logic [31:0]   d;
        logic [CB-1:0] c;
    } ent_t;

    ent_t          mq[$];
    logic [CB-1:0] m_cyc;
    bit            m_ovf;
    logic [CB-1:0] m_drop;
    bit            m_known = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic compare();
        if (!m_known) return;
        chk("deq_val",    64'(deq_val),    64'(mq.size() != 0));
        chk("count",      64'(count),      64'(mq.size()));
        chk("overflow",   64'(overflow),   64'(m_ovf));
        chk("drop_count", 64'(drop_count), 64'(m_drop));
        if (mq.size() != 0) begin
            chk("deq_addr",  64'(deq_addr),  64'(mq[0].a));
            chk("deq_data",  64'(deq_data),  64'(mq[0].d));
            chk("deq_cycle", 64'(deq_cycle), 64'(mq[0].c));
        end
    endtask

    // Called at a falling edge: drive inputs, advance the model past the
    // coming rising edge, then check the DUT at the next falling edge.
    task automatic step(input bit r, input bit cl, input bit e, input bit tv,
                        input logic [31:0] a, input logic [31:0] d, input bit rd);
        bit full, fire;
        rst = r; clear = cl; en = e; trace_val = tv;
        trace_addr = a; trace_data = d; deq_rdy = rd;
        if (r) begin
            mq.delete(); m_ovf = 0; m_drop = '0; m_cyc = '0; m_known = 1'b1;
        end else begin
            full = (mq.size() == DEPTH);
            fire = (mq.size() != 0) && rd;
            if (cl) begin
                mq.delete(); m_ovf = 0; m_drop = '0;
            end else begin
                if (fire) void'(mq.pop_front());
                if (tv && e) begin
                    if (!full || fire) mq.push_back('{a: a, d: d, c: m_cyc});
                    else begin
                        m_ovf = 1;
                        if (m_drop != {CB{1'b1}}) m_drop = m_drop + 1'b1;
                    end
                end
            end
            m_cyc = m_cyc + 1'b1;
        end
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        step(1, 0, 1, 0, 32'h0, 32'h0, 0);
    endtask

    task automatic beat(input logic [31:0] a, input bit rd);
        step(0, 0, 1, 1, a, $urandom, rd);
    endtask

    task automatic idle(input bit rd);
        step(0, 0, 1, 0, $urandom, $urandom, rd);
    endtask

    initial begin
        rst = 1; clear = 0; en = 0; trace_val = 0; deq_rdy = 0;
        trace_addr = '0; trace_data = '0;
        @(negedge clk);

        // 1: first beat after reset stamped with cycle 3
        do_reset();
        chk("t1_rst_val",   64'(deq_val), 64'd0);
        chk("t1_rst_count", 64'(count),   64'd0);
        idle(0); idle(0); idle(0);
        step(0, 0, 1, 1, 32'h0, 32'h5, 0);
        chk("t1_val",   64'(deq_val),   64'd1);
        chk("t1_addr",  64'(deq_addr),  64'h0);
        chk("t1_data",  64'(deq_data),  64'h5);
        chk("t1_cycle", 64'(deq_cycle), 64'd3);
        chk("t1_count", 64'(count),     64'd1);

        // 2: fill, two drops, drain in order
        do_reset();
        for (int i = 0; i < 10; i++) beat(32'(i * 4), 0);
        chk("t2_count",    64'(count),      64'd8);
        chk("t2_overflow", 64'(overflow),   64'd1);
        chk("t2_drops",    64'(drop_count), 64'd2);
        for (int i = 0; i < 8; i++) begin
            chk("t2_order", 64'(deq_addr), 64'(i * 4));
            idle(1);
        end
        chk("t2_empty", 64'(deq_val), 64'd0);

        // 3: full with simultaneous dequeue accepts the beat
        do_reset();
        for (int i = 0; i < 8; i++) beat(32'(i * 4), 0);
        beat(32'h100, 1);
        chk("t3_count",    64'(count),    64'd8);
        chk("t3_overflow", 64'(overflow), 64'd0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("t3_last", 64'(deq_addr), 64'h100);
            idle(1);
        end

        // 4: disabled capture ignores beats entirely
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, $urandom, $urandom, 0);
        chk("t4_count",    64'(count),      64'd0);
        chk("t4_overflow", 64'(overflow),   64'd0);
        chk("t4_drops",    64'(drop_count), 64'd0);

        // 5: clear flushes status, cycle counter continues
        do_reset();
        for (int i = 0; i < 9; i++) beat(32'(i), 0);        // stamps 0..8, one drop
        for (int i = 0; i < 5; i++) idle(1);                 // stamps 9..13
        chk("t5_pre_count", 64'(count),    64'd3);
        chk("t5_pre_ovf",   64'(overflow), 64'd1);
        step(0, 1, 1, 1, 32'h55, $urandom, 1);               // stamp 14
        chk("t5_count",    64'(count),      64'd0);
        chk("t5_val",      64'(deq_val),    64'd0);
        chk("t5_overflow", 64'(overflow),   64'd0);
        chk("t5_drops",    64'(drop_count), 64'd0);
        beat(32'h77, 0);                                     // stamp 15
        chk("t5_cycle", 64'(deq_cycle), 64'd15);

        // 6: reset mid-drain
        do_reset();
        for (int i = 0; i < 4; i++) beat(32'(i), 0);
        idle(1);
        step(1, 0, 1, 1, 32'h9, 32'h9, 1);
        chk("t6_val",   64'(deq_val),  64'd0);
        chk("t6_count", 64'(count),    64'd0);
        chk("t6_ovf",   64'(overflow), 64'd0);
        beat(32'hA, 0);
        chk("t6_cycle", 64'(deq_cycle), 64'd0);

        // drop counter saturates at all-ones
        do_reset();
        for (int i = 0; i < 8 + 70; i++) beat(32'(i), 0);
        chk("sat_drops", 64'(drop_count), 64'h3F);
        chk("sat_ovf",   64'(overflow),   64'd1);

        // randomized traffic; the model is checked every cycle
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int rdy_pct;
            rdy_pct = ((i / 200) % 3 == 0) ? 20 : (((i / 200) % 3 == 1) ? 80 : 50);
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 99) < 60,
                 $urandom, $urandom,
                 $urandom_range(0, 99) < rdy_pct);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
